// File: rtl/bitplane_pkg.sv
// Shared constants and types for the bit-plane zero-skip decompressor.
package bitplane_pkg;
    localparam int WORD_W   = 8;
    localparam int GROUP_SZ = 8;
    localparam int N_GROUPS = 2;
    localparam int N_WORDS  = GROUP_SZ * N_GROUPS;
    localparam int MEM_BW   = 128;
    localparam int MASK_W   = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef word_t [0:N_WORDS-1] block_t;

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        DONE
    } dec_state_t;
endpackage

// File: rtl/bitplane_decoder_lead_one_16.sv
// Combinational 16-bit leading-one detector; idx is the highest set bit, any flags a non-zero vector.
module lead_one_16 (
    input  logic [15:0] vec,
    output logic [3:0]  idx,
    output logic        any
);
    always_comb begin
        idx = 4'd0;
        any = 1'b0;
        // Ascending scan: the last hit is the most significant set bit.
        for (int b = 0; b < 16; b++) begin
            if (vec[b]) begin
                idx = 4'(b);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bitplane_decoder.sv
// Bit-plane zero-skip decompressor: rebuilds 16 bytes from a plane mask and packed planes, one plane per cycle.
// Optional payload-overrun check is enabled with the BPDEC_CHECK_EN macro (adds the err port).
//
// state  | meaning
// IDLE   | waiting for a compressed block, in_ready high
// DECODE | scattering one present plane per cycle into the output words
// DONE   | decoded block presented on out_valid until out_ready
module bitplane_decoder
    import bitplane_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MASK_W-1:0] mask,
    input  logic [MEM_BW-1:0] encoded,
    output logic              out_valid,
    input  logic              out_ready,
    output word_t             decoded [0:N_WORDS-1]
`ifdef BPDEC_CHECK_EN
    ,
    output logic              err
`endif
);
    if (MEM_BW != WORD_W * GROUP_SZ * N_GROUPS) begin : g_bw_check
        $error("MEM_BW must equal WORD_W*GROUP_SZ*N_GROUPS");
    end

    dec_state_t        state, state_nxt;
    logic [MASK_W-1:0] mask_r, mask_nxt;
    logic [MEM_BW-1:0] sh_r;
    block_t            dec_r;
    logic [3:0]        lead_idx;
    logic              lead_any;
    logic              accept;

    lead_one_16 u_lead (
        .vec (mask_r),
        .idx (lead_idx),
        .any (lead_any)
    );

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;

    always_comb begin
        mask_nxt           = mask_r;
        mask_nxt[lead_idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (mask == '0) ? DONE : DECODE;
            end
            DECODE: begin
                if (!lead_any || mask_nxt == '0) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_r <= '0;
            sh_r   <= '0;
            dec_r  <= '0;
        end else if (state == IDLE) begin
            if (accept) begin
                mask_r <= mask;
                sh_r   <= encoded;
                dec_r  <= '0;
            end
        end else if (state == DECODE) begin
            // Group 0 owns the upper mask byte, so its word base is selected by ~p[3].
            for (int j = 0; j < GROUP_SZ; j++) begin
                dec_r[{~lead_idx[3], 3'(j)}][lead_idx[2:0]] <= sh_r[MEM_BW-1-j];
            end
            sh_r   <= sh_r << WORD_W;
            mask_r <= mask_nxt;
        end
    end

    always_comb begin
        for (int w = 0; w < N_WORDS; w++) decoded[w] = dec_r[w];
    end

`ifdef BPDEC_CHECK_EN
    logic err_r;

    // Any payload left after the last declared plane means the mask under-describes the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (accept) err_r <= (mask == '0) ? (|encoded) : 1'b0;
                DECODE:  if (mask_nxt == '0) err_r <= |(sh_r << WORD_W);
                DONE:    if (out_ready) err_r <= 1'b0;
                default: err_r <= 1'b0;
            endcase
        end
    end

    assign err = err_r;
`endif
endmodule

// File: tb/tb_bitplane_decoder.sv
// Directed bench for bitplane_decoder: hand-computed vectors, encoder-model round trips, backpressure and reset abort.
module tb_bitplane_decoder;
    import bitplane_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [MASK_W-1:0] mask = '0;
    logic [MEM_BW-1:0] encoded = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    word_t             decoded [0:N_WORDS-1];
`ifdef BPDEC_CHECK_EN
    logic              err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    bitplane_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mask      (mask),
        .encoded   (encoded),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .decoded   (decoded)
`ifdef BPDEC_CHECK_EN
        ,
        .err       (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Word 0 occupies the top byte of the flattened view.
    function automatic logic [127:0] flat_dec();
        logic [127:0] f = '0;
        for (int w = 0; w < N_WORDS; w++) f[127-8*w -: 8] = decoded[w];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference encoder: group 0 then group 1, planes 7 down to 0, empty planes skipped.
    function automatic void encode(input logic [127:0] words, output logic [15:0] m,
                                   output logic [127:0] e, output int p);
        int pos = 127;
        m = '0;
        e = '0;
        p = 0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 7; i >= 0; i--) begin
                logic present = 1'b0;
                for (int j = 0; j < 8; j++) if (words[127-8*(k*8+j)-(7-i)]) present = 1'b1;
                if (present) begin
                    m[8*(1-k)+i] = 1'b1;
                    for (int j = 0; j < 8; j++) e[pos-j] = words[127-8*(k*8+j)-(7-i)];
                    pos -= 8;
                    p++;
                end
            end
        end
    endfunction

    task automatic run_block(input string tag, input logic [15:0] m, input logic [127:0] e,
                             input logic [127:0] exp_words, input int exp_lat, input logic exp_err);
        int lat;
        check({tag, ".in_ready"}, 128'(in_ready), 128'(1'b1));
        in_valid = 1'b1;
        mask     = m;
        encoded  = e;
        tick();
        in_valid = 1'b0;
        mask     = $urandom;
        encoded  = {4{$urandom}};
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 128'(lat), 128'(exp_lat));
        check({tag, ".decoded"}, flat_dec(), exp_words);
`ifdef BPDEC_CHECK_EN
        check({tag, ".err"}, 128'(err), 128'(exp_err));
`else
        if (exp_err) begin end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, ".drop_valid"}, 128'(out_valid), 128'(1'b0));
        check({tag, ".hold_idle"}, flat_dec(), exp_words);
    endtask

    initial begin
        logic [127:0] words, enc;
        logic [15:0]  m;
        int           p;

        tick();
        tick();
        check("reset.out_valid", 128'(out_valid), 128'(1'b0));
        check("reset.in_ready", 128'(in_ready), 128'(1'b0));
        check("reset.decoded", flat_dec(), 128'h0);
`ifdef BPDEC_CHECK_EN
        check("reset.err", 128'(err), 128'(1'b0));
`endif
        rst = 1'b0;
        #1;
        check("reset.release_ready", 128'(in_ready), 128'(1'b1));

        run_block("t1_empty", 16'h0000, 128'h0, 128'h0, 1, 1'b0);
        run_block("t2_top", 16'h8000, 128'h1 << 127, 128'h80 << 120, 2, 1'b0);
        run_block("t3_bottom", 16'h0001, 128'h80 << 120, 128'h01 << 56, 2, 1'b0);
        run_block("t4_full", 16'hFFFF, {128{1'b1}}, {128{1'b1}}, 17, 1'b0);
        run_block("t5_two", 16'h0180, 128'hA53C << 112,
                  128'h01000100_00010001_00008080_80800000, 3, 1'b0);
        run_block("t6_leftover", 16'h8000, 128'h1, 128'h0, 2, 1'b1);

        for (int n = 0; n < 30; n++) begin
            logic [7:0] pe0 = 8'($urandom);
            logic [7:0] pe1 = 8'($urandom);
            for (int w = 0; w < 16; w++) words[127-8*w -: 8] = 8'($urandom) & ((w < 8) ? pe0 : pe1);
            encode(words, m, enc, p);
            run_block("rt", m, enc, words, p + 1, 1'b0);
        end

        // Backpressure in DONE with in_valid pulses.
        in_valid = 1'b1;
        mask     = 16'h8000;
        encoded  = 128'h1 << 127;
        tick();
        in_valid = 1'b0;
        tick();
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0];
            mask     = 16'hFFFF;
            encoded  = {128{1'b1}};
            tick();
            check("bp.out_valid", 128'(out_valid), 128'(1'b1));
            check("bp.in_ready", 128'(in_ready), 128'(1'b0));
            check("bp.decoded", flat_dec(), 128'h80 << 120);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp.release_valid", 128'(out_valid), 128'(1'b0));
        check("bp.release_ready", 128'(in_ready), 128'(1'b1));

        // Reset in the third DECODE cycle of a full block.
        in_valid = 1'b1;
        mask     = 16'hFFFF;
        encoded  = {128{1'b1}};
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("abort.out_valid", 128'(out_valid), 128'(1'b0));
        check("abort.decoded", flat_dec(), 128'h0);
        rst = 1'b0;
        #1;
        check("abort.idle", 128'(in_ready), 128'(1'b1));
        run_block("post_abort_leftover", 16'h8000, 128'h1, 128'h0, 2, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
